// File: rtl/syn_pc_predict_pkg.sv
// ---------------------------------------------------------------------------
// syn_pc_predict_pkg
//   Shared definitions for the fetch PC predictor: default address width,
//   branch-kind encoding, 2-bit counter constants and the counter step helper.
// ---------------------------------------------------------------------------
package syn_pc_predict_pkg;

   localparam int unsigned ADDR_W_DEF = 10;

   typedef enum logic [1:0] {
      KIND_BR   = 2'd0,
      KIND_JMP  = 2'd1,
      KIND_CALL = 2'd2,
      KIND_RET  = 2'd3
   } kind_e;

   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   // Saturating 2-bit counter step toward the resolved direction.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != 2'b11) res = ctr + 2'd1;
      end else begin
         if (ctr != 2'b00) res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/syn_pc_predict_ras.sv
// ---------------------------------------------------------------------------
// syn_ras
//   Circular return-address stack. A push when full overwrites the oldest
//   entry; the occupancy count saturates at DEPTH. A pop when empty is a
//   no-op. Push takes priority if both are requested.
// Ports
//   clk, rst_n  clock / async active-low reset
//   push        write push_data at the top
//   pop         discard the top entry (ignored when empty)
//   push_data   return address to store
//   top         most recently pushed entry
//   empty       no entries held
// ---------------------------------------------------------------------------
module syn_ras #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] ptr;      // next free slot
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] top_idx;

   assign top_idx = ptr - PTR_W'(1);
   assign top     = mem[top_idx];
   assign empty   = (count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[ptr] <= push_data;
         ptr      <= ptr + PTR_W'(1);
         if (count != FULL) count <= count + (PTR_W+1)'(1);
      end else if (pop && !empty) begin
         ptr   <= top_idx;
         count <= count - (PTR_W+1)'(1);
      end
   end

endmodule

// File: rtl/syn_pc_predict.sv
// ---------------------------------------------------------------------------
// syn_pc_predict
//   Fetch PC unit. Holds the fetch PC and predicts the next PC from a
//   direct-mapped BTB (2-bit counters, per-entry branch kind) plus a
//   speculative return-address stack. Redirected and trained by EX.
// Ports
//   clk, rst_n     clock / async active-low reset
//   en             global enable; 0 freezes all state
//   stall          hold PC
//   redirect       load redirect_addr (overrides stall)
//   redirect_addr  corrected PC
//   upd_valid      train BTB this cycle
//   upd_pc         PC of resolved branch/jump
//   upd_target     resolved target
//   upd_taken      resolved direction
//   upd_kind       BR=0 JMP=1 CALL=2 RET=3
//   pc             current fetch PC
//   pc_4           pc+1 (wraps)
//   pred_hit       BTB tag hit for pc
//   pred_taken     predicted next PC differs from pc_4
// ---------------------------------------------------------------------------
module syn_pc_predict
   import syn_pc_predict_pkg::*;
#(
   parameter int unsigned     ADDR_W    = ADDR_W_DEF,
   parameter int unsigned     BTB_IDX_W = 4,
   parameter int unsigned     RAS_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_taken,
   input  logic [1:0]        upd_kind,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_4,
   output logic              pred_hit,
   output logic              pred_taken
);

   localparam int unsigned BTB_DEPTH = 2**BTB_IDX_W;
   localparam int unsigned TAG_W     = ADDR_W - BTB_IDX_W;

   logic              btb_valid  [BTB_DEPTH];
   logic [TAG_W-1:0]  btb_tag    [BTB_DEPTH];
   logic [ADDR_W-1:0] btb_target [BTB_DEPTH];
   logic [1:0]        btb_ctr    [BTB_DEPTH];
   kind_e             btb_kind   [BTB_DEPTH];

   logic [BTB_IDX_W-1:0] idx;
   logic [TAG_W-1:0]     tag;
   logic                 use_ras;
   logic                 use_tgt;
   logic [ADDR_W-1:0]    next_pc;
   logic                 advance;

   logic [ADDR_W-1:0]    ras_top;
   logic                 ras_empty;
   logic                 ras_push;
   logic                 ras_pop;

   logic [BTB_IDX_W-1:0] u_idx;
   logic [TAG_W-1:0]     u_tag;
   logic                 u_hit;
   kind_e                u_kind;

   // Lookup on the current fetch PC
   assign idx      = pc[BTB_IDX_W-1:0];
   assign tag      = pc[ADDR_W-1:BTB_IDX_W];
   assign pc_4     = pc + ADDR_W'(1);
   assign pred_hit = btb_valid[idx] && (btb_tag[idx] == tag);
   assign use_ras  = pred_hit && (btb_kind[idx] == KIND_RET) && !ras_empty;
   assign use_tgt  = pred_hit && btb_ctr[idx][1];

   always_comb begin
      next_pc = pc_4;
      if (use_ras)      next_pc = ras_top;
      else if (use_tgt) next_pc = btb_target[idx];
   end

   assign pred_taken = (next_pc != pc_4);

   // RAS only moves when the PC follows its own prediction
   assign advance  = en && !redirect && !stall;
   assign ras_push = advance && use_tgt && !use_ras && (btb_kind[idx] == KIND_CALL);
   assign ras_pop  = advance && use_ras;

   syn_ras #(
      .DEPTH (RAS_DEPTH),
      .W     (ADDR_W)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_4),
      .top       (ras_top),
      .empty     (ras_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (en) begin
         if (redirect)   pc <= redirect_addr;
         else if (!stall) pc <= next_pc;
      end
   end

   // Training port
   assign u_idx  = upd_pc[BTB_IDX_W-1:0];
   assign u_tag  = upd_pc[ADDR_W-1:BTB_IDX_W];
   assign u_hit  = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
   assign u_kind = kind_e'(upd_kind);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_ctr[i]    <= CTR_WNT;
            btb_kind[i]   <= KIND_BR;
         end
      end else if (en && upd_valid) begin
         if (u_hit) begin
            btb_ctr[u_idx] <= (u_kind != KIND_BR) ? CTR_ST : ctr_step(btb_ctr[u_idx], upd_taken);
            if (upd_taken) begin
               btb_target[u_idx] <= upd_target;
               btb_kind[u_idx]   <= u_kind;
            end
         end else if (upd_taken) begin
            btb_valid[u_idx]  <= 1'b1;
            btb_tag[u_idx]    <= u_tag;
            btb_target[u_idx] <= upd_target;
            btb_kind[u_idx]   <= u_kind;
            btb_ctr[u_idx]    <= (u_kind != KIND_BR) ? CTR_ST : CTR_WT;
         end
      end
   end

endmodule
